// File: rtl/id_exe_feed.sv
// ID/EXE pipeline register with EXE/MEM operand forwarding, load-use stall and flush bubbles.
// Latency: one cycle ID->EXE; stall is combinational and the bubble it inserts clears the hazard next cycle.
module id_exe_feed #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [4:0]       drs,
    input  logic [4:0]       drt,
    input  logic             dusers,
    input  logic             dusert,
    input  logic [4:0]       drn,
    input  logic             dwreg,
    input  logic             dm2reg,
    input  logic             dwmem,
    input  logic [2:0]       daluc,
    input  logic             daluimm,
    input  logic             dshift,
    input  logic [WIDTH-1:0] qa,
    input  logic [WIDTH-1:0] qb,
    input  logic [WIDTH-1:0] dimm,
    input  logic [WIDTH-1:0] dpc4,
    input  logic             dflush,
    input  logic [WIDTH-1:0] ealu,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic [4:0]       mrn,
    input  logic [WIDTH-1:0] malu,
    input  logic [WIDTH-1:0] mmo,
    input  logic             cnt_clr,
    output logic             stall,
    output logic             evalid,
    output logic             ewreg,
    output logic             em2reg,
    output logic             ewmem,
    output logic [2:0]       ealuc,
    output logic             ealuimm,
    output logic             eshift,
    output logic [4:0]       ern,
    output logic [WIDTH-1:0] ea,
    output logic [WIDTH-1:0] eb,
    output logic [WIDTH-1:0] eimm,
    output logic [WIDTH-1:0] epc4,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;
    logic             bubble;

    // EXE beats MEM; a load still in EXE cannot forward (handled by stall instead).
    function automatic logic [WIDTH-1:0] pick(
        input logic [4:0]       rn,
        input logic [WIDTH-1:0] q,
        input logic             x_wreg,
        input logic             x_m2reg,
        input logic [4:0]       x_rn,
        input logic [WIDTH-1:0] x_alu,
        input logic             m_wreg,
        input logic             m_m2reg,
        input logic [4:0]       m_rn,
        input logic [WIDTH-1:0] m_alu,
        input logic [WIDTH-1:0] m_mo
    );
        logic [WIDTH-1:0] r;
        r = q;
        if (x_wreg && !x_m2reg && x_rn != 5'd0 && x_rn == rn)
            r = x_alu;
        else if (m_wreg && m_rn != 5'd0 && m_rn == rn)
            r = m_m2reg ? m_mo : m_alu;
        return r;
    endfunction

    always_comb begin
        fwd_a  = pick(drs, qa, ewreg, em2reg, ern, ealu, mwreg, mm2reg, mrn, malu, mmo);
        fwd_b  = pick(drt, qb, ewreg, em2reg, ern, ealu, mwreg, mm2reg, mrn, malu, mmo);
        stall  = ewreg && em2reg && (ern != 5'd0) &&
                 ((dusers && ern == drs) || (dusert && ern == drt));
        bubble = stall || dflush;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            evalid  <= 1'b0;
            ewreg   <= 1'b0;
            em2reg  <= 1'b0;
            ewmem   <= 1'b0;
            ealuc   <= 3'd0;
            ealuimm <= 1'b0;
            eshift  <= 1'b0;
            ern     <= 5'd0;
            ea      <= '0;
            eb      <= '0;
            eimm    <= '0;
            epc4    <= '0;
        end else begin
            ea      <= fwd_a;
            eb      <= fwd_b;
            eimm    <= dimm;
            epc4    <= dpc4;
            ern     <= drn;
            ealuc   <= daluc;
            ealuimm <= daluimm;
            eshift  <= dshift;
            if (bubble) begin
                ewreg  <= 1'b0;
                em2reg <= 1'b0;
                ewmem  <= 1'b0;
                evalid <= 1'b0;
            end else begin
                ewreg  <= dwreg;
                em2reg <= dm2reg;
                ewmem  <= dwmem;
                evalid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            bubble_cnt <= '0;
        else if (cnt_clr)
            bubble_cnt <= '0;
        else if (bubble && !(&bubble_cnt))
            bubble_cnt <= bubble_cnt + 1'b1;
    end

endmodule

// File: tb/tb_id_exe_feed.sv
// Directed bench for id_exe_feed: chained vector table plus saturation and async-reset sequences.
module tb_id_exe_feed;

    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          clrn;
    logic [4:0]    drs, drt, drn, mrn;
    logic          dusers, dusert, dwreg, dm2reg, dwmem, daluimm, dshift, dflush;
    logic [2:0]    daluc;
    logic [W-1:0]  qa, qb, dimm, dpc4, ealu, malu, mmo;
    logic          mwreg, mm2reg, cnt_clr;
    logic          stall, evalid, ewreg, em2reg, ewmem, ealuimm, eshift;
    logic [2:0]    ealuc;
    logic [4:0]    ern;
    logic [W-1:0]  ea, eb, eimm, epc4;
    logic [CW-1:0] bubble_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_exe_feed #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .clrn(clrn), .drs(drs), .drt(drt), .dusers(dusers), .dusert(dusert),
        .drn(drn), .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .daluc(daluc),
        .daluimm(daluimm), .dshift(dshift), .qa(qa), .qb(qb), .dimm(dimm), .dpc4(dpc4),
        .dflush(dflush), .ealu(ealu), .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn),
        .malu(malu), .mmo(mmo), .cnt_clr(cnt_clr), .stall(stall), .evalid(evalid),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ealuc(ealuc), .ealuimm(ealuimm),
        .eshift(eshift), .ern(ern), .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4),
        .bubble_cnt(bubble_cnt)
    );

    typedef struct {
        logic [4:0]   drs, drt, drn, mrn;
        logic         dusers, dusert, dwreg, dm2reg, dflush, cnt_clr, mwreg, mm2reg;
        logic [W-1:0] qa, qb, ealu, malu, mmo;
        logic         x_stall, x_ewreg, x_em2reg, x_evalid;
        logic [4:0]   x_ern;
        logic [W-1:0] x_ea, x_eb;
        logic [CW-1:0] x_cnt;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic [4:0] i_drs, input logic [4:0] i_drt, input logic i_us, input logic i_ut,
        input logic [W-1:0] i_qa, input logic [W-1:0] i_qb,
        input logic [4:0] i_drn, input logic i_wreg, input logic i_m2reg,
        input logic i_flush, input logic i_clr,
        input logic [W-1:0] i_ealu, input logic i_mwreg, input logic i_mm2reg,
        input logic [4:0] i_mrn, input logic [W-1:0] i_malu, input logic [W-1:0] i_mmo,
        input logic e_stall, input logic [W-1:0] e_ea, input logic [W-1:0] e_eb,
        input logic e_wreg, input logic e_m2reg, input logic e_valid,
        input logic [4:0] e_rn, input logic [CW-1:0] e_cnt);
        vec_t v;
        v.drs = i_drs; v.drt = i_drt; v.dusers = i_us; v.dusert = i_ut;
        v.qa = i_qa; v.qb = i_qb; v.drn = i_drn; v.dwreg = i_wreg; v.dm2reg = i_m2reg;
        v.dflush = i_flush; v.cnt_clr = i_clr; v.ealu = i_ealu; v.mwreg = i_mwreg;
        v.mm2reg = i_mm2reg; v.mrn = i_mrn; v.malu = i_malu; v.mmo = i_mmo;
        v.x_stall = e_stall; v.x_ea = e_ea; v.x_eb = e_eb; v.x_ewreg = e_wreg;
        v.x_em2reg = e_m2reg; v.x_evalid = e_valid; v.x_ern = e_rn; v.x_cnt = e_cnt;
        return v;
    endfunction

    task automatic idle_inputs();
        drs = 0; drt = 0; drn = 0; mrn = 0; dusers = 0; dusert = 0; dwreg = 0;
        dm2reg = 0; dwmem = 0; daluimm = 0; dshift = 0; dflush = 0; daluc = 0;
        qa = 0; qb = 0; dimm = 0; dpc4 = 0; ealu = 0; malu = 0; mmo = 0;
        mwreg = 0; mm2reg = 0; cnt_clr = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"}, W'(stall), 0);
        chk({tag, "_evalid"}, W'(evalid), 0);
        chk({tag, "_ewreg"}, W'(ewreg), 0);
        chk({tag, "_em2reg"}, W'(em2reg), 0);
        chk({tag, "_ewmem"}, W'(ewmem), 0);
        chk({tag, "_ctl"}, W'({ealuc, ealuimm, eshift, ern}), 0);
        chk({tag, "_ea"}, ea, 0);
        chk({tag, "_eb"}, eb, 0);
        chk({tag, "_eimm"}, eimm, 0);
        chk({tag, "_epc4"}, epc4, 0);
        chk({tag, "_cnt"}, W'(bubble_cnt), 0);
    endtask

    initial begin
        // ID fields, forward sources, then expected {stall, ea, eb, ewreg, em2reg, evalid, ern, cnt}
        vt[0] = mk(1, 2, 1, 1, 32'h11, 32'h22, 3, 1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0,
                   0, 32'h11, 32'h22, 1, 0, 1, 3, 0);
        vt[1] = mk(3, 2, 1, 1, 32'h99, 32'h22, 5, 1, 0, 0, 0, 32'h10, 0, 0, 0, 32'h0, 32'h0,
                   0, 32'h10, 32'h22, 1, 0, 1, 5, 0);
        vt[2] = mk(0, 5, 1, 1, 32'h77, 32'h55, 0, 1, 0, 0, 0, 32'hA, 1, 0, 5, 32'hB, 32'h0,
                   0, 32'h77, 32'hA, 1, 0, 1, 0, 0);
        vt[3] = mk(0, 6, 1, 1, 32'h33, 32'h66, 4, 1, 1, 0, 0, 32'hDEAD, 1, 0, 0, 32'hBEEF, 32'h0,
                   0, 32'h33, 32'h66, 1, 1, 1, 4, 0);
        vt[4] = mk(7, 4, 0, 1, 32'h70, 32'h44, 8, 1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0,
                   1, 32'h70, 32'h44, 0, 0, 0, 8, 1);
        vt[5] = mk(7, 4, 0, 1, 32'h70, 32'h44, 8, 1, 0, 0, 0, 32'h0, 1, 1, 4, 32'h1, 32'h4444,
                   0, 32'h70, 32'h4444, 1, 0, 1, 8, 1);
        vt[6] = mk(1, 2, 1, 1, 32'h1, 32'h2, 9, 1, 0, 1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0,
                   0, 32'h1, 32'h2, 0, 0, 0, 9, 2);
        vt[7] = mk(1, 2, 1, 1, 32'h1, 32'h2, 10, 1, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0,
                   0, 32'h1, 32'h2, 1, 1, 1, 10, 2);
        vt[8] = mk(10, 2, 1, 0, 32'hA0, 32'h2, 11, 1, 0, 1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0,
                   1, 32'hA0, 32'h2, 0, 0, 0, 11, 3);
        vt[9] = mk(1, 2, 1, 1, 32'h5, 32'h6, 12, 1, 0, 1, 1, 32'h0, 0, 0, 0, 32'h0, 32'h0,
                   0, 32'h5, 32'h6, 0, 0, 0, 12, 0);

        clrn = 1'b0;
        idle_inputs();
        repeat (3) begin
            @(negedge clk);
            drs = 5'($urandom); drt = 5'($urandom); drn = 5'($urandom);
            dusers = 1'($urandom); dusert = 1'($urandom); dwreg = 1'($urandom);
            dm2reg = 1'($urandom); qa = $urandom; qb = $urandom; ealu = $urandom;
            mwreg = 1'($urandom); mrn = 5'($urandom); malu = $urandom; mmo = $urandom;
        end
        #1;
        check_all_zero("reset");
        @(negedge clk);
        idle_inputs();
        clrn = 1'b1;
        @(posedge clk);
        #1;

        // Table: inputs applied just after an edge, stall sampled before the next, state after it.
        for (int i = 0; i < 10; i++) begin
            drs = vt[i].drs; drt = vt[i].drt; dusers = vt[i].dusers; dusert = vt[i].dusert;
            qa = vt[i].qa; qb = vt[i].qb; drn = vt[i].drn; dwreg = vt[i].dwreg;
            dm2reg = vt[i].dm2reg; dflush = vt[i].dflush; cnt_clr = vt[i].cnt_clr;
            ealu = vt[i].ealu; mwreg = vt[i].mwreg; mm2reg = vt[i].mm2reg; mrn = vt[i].mrn;
            malu = vt[i].malu; mmo = vt[i].mmo;
            dwmem = vt[i].dwreg; daluc = 3'(i); daluimm = 1'(i); dshift = 1'(i >> 1);
            dimm = 32'h1000 + 32'(i); dpc4 = 32'(4 * (i + 1));
            #1;
            chk($sformatf("v%0d_stall", i), W'(stall), W'(vt[i].x_stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ea", i), ea, vt[i].x_ea);
            chk($sformatf("v%0d_eb", i), eb, vt[i].x_eb);
            chk($sformatf("v%0d_ctl", i), W'({ewreg, em2reg, evalid, ewmem}),
                W'({vt[i].x_ewreg, vt[i].x_em2reg, vt[i].x_evalid, vt[i].x_ewreg}));
            chk($sformatf("v%0d_ern", i), W'(ern), W'(vt[i].x_ern));
            chk($sformatf("v%0d_cnt", i), W'(bubble_cnt), W'(vt[i].x_cnt));
            chk($sformatf("v%0d_imm", i), eimm, 32'h1000 + 32'(i));
            chk($sformatf("v%0d_pc4", i), epc4, 32'(4 * (i + 1)));
            chk($sformatf("v%0d_alu", i), W'({ealuc, ealuimm, eshift}),
                W'({3'(i), 1'(i), 1'(i >> 1)}));
        end

        // Saturation: counter is 0 here; 20 flush bubbles must stop at all-ones.
        idle_inputs();
        dflush = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("sat_reach", W'(bubble_cnt), W'({CW{1'b1}}));
        @(posedge clk);
        #1;
        chk("sat_hold", W'(bubble_cnt), W'({CW{1'b1}}));
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_with_bubble", W'(bubble_cnt), 0);

        // Async reset during a load-use stall.
        idle_inputs();
        drn = 5'd7; dwreg = 1'b1; dm2reg = 1'b1; qa = 32'h123;
        @(posedge clk);
        #1;
        drn = 5'd2; dm2reg = 1'b0; drs = 5'd7; dusers = 1'b1; qa = 32'h456;
        #1;
        chk("mid_stall", W'(stall), 1);
        #2;
        clrn = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_valid", W'({evalid, ewreg, em2reg}), W'(3'b110));
        chk("post_rst_ea", ea, 32'h456);
        chk("post_rst_cnt", W'(bubble_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
